// File: rtl/cards_pkg.sv
// cards_pkg: shared FSM states, op codes and header-flag position for the card-list allocator
package cards_pkg;
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_RD, S_WAIT, S_CHK, S_WR, S_DONE} state_t;
  localparam logic ALLOC_OP = 1'b0;
  localparam logic FREE_OP = 1'b1;
  function automatic int flag_pos(input int data_w);
    return data_w - 1;
  endfunction
endpackage

// File: rtl/block_ptr.sv
// block_ptr: next-fit block pointer wrapping from the last block to 1, with probe counter
// Ports: clock/resetn (async active-low), i_clr restarts the probe count,
// i_step advances the pointer and counts a probe, o_ptr block index,
// o_exhausted high while the current probe is the last one a full sweep allows.
module block_ptr #(
  parameter int BW = 10
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          i_clr,
  input  logic          i_step,
  output logic [BW-1:0] o_ptr,
  output logic          o_exhausted
);
  localparam logic [BW-1:0] LAST = BW'((1 << BW) - 2);
  logic [BW-1:0] r_ptr, r_probe;
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_ptr   <= BW'(1);
      r_probe <= '0;
    end else begin
      if (i_clr) r_probe <= '0;
      else if (i_step) r_probe <= r_probe + 1'b1;
      if (i_step) r_ptr <= &r_ptr ? BW'(1) : r_ptr + 1'b1;
    end
  end
  assign o_ptr = r_ptr;
  assign o_exhausted = r_probe == LAST;
endmodule

// File: rtl/block_allocator.sv
// block_allocator: next-fit heap allocator owning the single port of the card-list RAM
// Ports: clock/resetn (async active-low); req/op/free_addr request in, busy/done/ok/
// out_address/used_count status out; ram_address/ram_clock/ram_data/ram_wren/ram_q RAM port.
// Define ALLOC_FREE_CHECK_EN to make a free read the header first and reject double frees.
import cards_pkg::*;
module block_allocator #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int BLOCK_WORDS = 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req,
  input  logic              op,
  input  logic [ADDR_W-1:0] free_addr,
  output logic              busy,
  output logic              done,
  output logic              ok,
  output logic [ADDR_W-1:0] out_address,
  output logic [ADDR_W:0]   used_count,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_clock,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);
  localparam int OFS = $clog2(BLOCK_WORDS);
  localparam int BW = ADDR_W - OFS;
  localparam int FLAG = flag_pos(DATA_W);
  localparam logic [ADDR_W:0] MAX_USED = (ADDR_W+1)'((1 << BW) - 1);
  localparam logic [ADDR_W-1:0] MASK = ADDR_W'(BLOCK_WORDS - 1);
`ifdef ALLOC_FREE_CHECK_EN
  localparam bit FREE_CHECK = 1'b1;
`else
  localparam bit FREE_CHECK = 1'b0;
`endif
  state_t            r_state, w_next;
  logic [BW-1:0]     r_init, w_ptr;
  logic              r_op, r_ok, w_exh, w_step, w_clr, w_flag, w_free_ok;
  logic [ADDR_W-1:0] r_addr, r_out, w_ptr_addr;
  logic [ADDR_W:0]   r_used;
  block_ptr #(.BW(BW)) u_ptr (
    .clock(clock), .resetn(resetn), .i_clr(w_clr), .i_step(w_step),
    .o_ptr(w_ptr), .o_exhausted(w_exh)
  );
  assign w_ptr_addr = ADDR_W'(w_ptr) << OFS;
  assign w_flag = ram_q[FLAG];
  assign w_free_ok = (free_addr & MASK) == '0 && free_addr != '0;
  assign w_clr = r_state == S_IDLE && req;
  // every alloc miss advances, so a full failed sweep lands back on the start block
  assign w_step = r_op == ALLOC_OP && ((r_state == S_CHK && w_flag) || r_state == S_WR);
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= S_INIT;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT: w_next = &r_init ? S_IDLE : S_INIT;
      S_IDLE: w_next = !req ? S_IDLE : op == ALLOC_OP ? S_RD : !w_free_ok ? S_DONE : FREE_CHECK ? S_RD : S_WR;
      S_RD:   w_next = S_WAIT;
      S_WAIT: w_next = S_CHK;
      S_CHK:  w_next = r_op == ALLOC_OP ? (!w_flag ? S_WR : w_exh ? S_DONE : S_RD) : (w_flag ? S_WR : S_DONE);
      S_WR:   w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_INIT;
    endcase
  end
  always_comb begin
    busy = r_state != S_IDLE;
    done = r_state == S_DONE;
    ram_wren = resetn && (r_state == S_INIT || r_state == S_WR);
    ram_address = r_state == S_INIT ? ADDR_W'(r_init) << OFS :
                  r_state inside {S_RD, S_WAIT, S_CHK, S_WR} ? (r_op == FREE_OP ? r_addr : w_ptr_addr) : '0;
    ram_data = (r_state == S_WR && r_op == ALLOC_OP) ? DATA_W'(1) << FLAG : '0;
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_init <= '0;
      r_op   <= ALLOC_OP;
      r_addr <= '0;
      r_ok   <= 1'b0;
      r_out  <= '0;
      r_used <= '0;
    end else begin
      if (r_state == S_INIT) r_init <= r_init + 1'b1;
      if (w_clr) begin
        r_op   <= op;
        r_addr <= free_addr;
        r_ok   <= 1'b0;
        r_out  <= '0;
      end
      if (r_state == S_WR) begin
        r_ok   <= 1'b1;
        r_out  <= r_op == ALLOC_OP ? w_ptr_addr : '0;
        r_used <= r_op == ALLOC_OP ? r_used + (ADDR_W+1)'(r_used != MAX_USED) : r_used - (ADDR_W+1)'(r_used != '0);
      end
    end
  end
  assign ok = r_ok;
  assign out_address = r_out;
  assign used_count = r_used;
  assign ram_clock = clock;
endmodule

// File: doc/block_allocator.md
# block_allocator

Parametrised heap allocator for the card-list RAM. Owns the single port of a synchronous RAM and services one allocate or free request at a time over a req/done handshake. Allocation uses next-fit scanning of block headers, where header MSB = 1 means in use. Sits between the list operation controller (add card, remove nth card, split list) and the RAM, and replaces the fixed 1024x32, clockless-reset allocator.

## Interface
Parameters:
- ADDR_W, 10, RAM word-address width
- DATA_W, 32, RAM word width; MSB is the allocated flag
- BLOCK_WORDS, 1, words per block (power of two, ≤ 2^ADDR_W/2); NUM_BLOCKS = 2^ADDR_W / BLOCK_WORDS

Ports:
- clock  in  1  system clock; also forwarded as ram_clock
- resetn  in  1  asynchronous, active-low reset
- req  in  1  request strobe; sampled only when busy = 0
- op  in  1  0 = allocate, 1 = free
- free_addr  in  ADDR_W  block base address to free
- busy  out  1  high from request accept (and during init) until the cycle after done
- done  out  1  one-cycle completion pulse
- ok  out  1  result of the last operation, valid with done and held until the next accept
- out_address  out  ADDR_W  allocated base address; 0 on failure
- used_count  out  ADDR_W+1  number of blocks currently allocated
- ram_address  out  ADDR_W  RAM address
- ram_clock  out  1  equal to clock
- ram_data  out  DATA_W  RAM write data
- ram_wren  out  1  RAM write enable
- ram_q  in  DATA_W  RAM read data, valid one cycle after the address is presented

## Operation
- Block k has base address k·BLOCK_WORDS. Block 0 is reserved as the null pointer and is never allocated.
- States:
  - INIT: writes header 0 to every block base, 0 to NUM_BLOCKS-1, one write per cycle, then goes to IDLE.
  - IDLE, RD, WAIT, CHK, WR, DONE.
- IDLE with req = 1: latch op and free_addr, then go to RD (alloc) or WR (free).
- Alloc:
  - RD drives ram_address = ptr; WAIT; CHK inspects ram_q[DATA_W-1].
  - Flag = 0: go to WR, which writes {1, 0…} to ptr. Then out_address = ptr, ok = 1, used_count+1, and ptr advances to the next block.
  - Flag = 1: advance ptr (wrapping from NUM_BLOCKS-1 to 1) and return to RD.
  - After NUM_BLOCKS-1 probes with no hit: go to DONE with ok = 0 and out_address = 0. ptr is unchanged, and no write occurs.
- Free:
  - free_addr that is unaligned or zero: DONE with ok = 0 and no write.
  - Otherwise WR writes 0 to free_addr, sets ok = 1, and decrements used_count.
- DONE: done = 1 for one cycle, then IDLE.
- ram_wren is high only in INIT and WR. ram_data is 0 in all other cycles.

## Timing
- Reset values:
  - state = INIT, ptr = 1, busy = 1.
  - done = 0, ok = 0, out_address = 0, used_count = 0.
  - ram_address = 0, ram_data = 0, ram_wren = 0.
- Reset asserted mid-operation aborts immediately and ram_wren drops asynchronously. INIT reruns, so RAM headers are rebuilt.
- Init takes NUM_BLOCKS cycles; busy falls in the first IDLE cycle.
- Cycle numbering takes the accept cycle as 0:
  - Alloc hitting on probe k: done in cycle 3k+2.
  - Alloc failure: done in cycle 3(NUM_BLOCKS-1)+1.
  - Free: done in cycle 2.
  - Rejected free: done in cycle 1.
- req while busy = 1 is ignored, with no queueing.
- used_count saturates at NUM_BLOCKS-1 and floors at 0.

## Configuration
- ALLOC_FREE_CHECK_EN defined: a free first reads the header (RD, WAIT, CHK).
  - Header flag already 0 (double free): DONE with ok = 0, no write, used_count unchanged. Done in cycle 4.
  - Otherwise go to WR; done in cycle 5.
- ALLOC_FREE_CHECK_EN undefined: a free writes blindly and decrements used_count on any aligned nonzero address.

## Structure
- Shared package (cards_pkg):
  - state encoding
  - op codes ALLOC_OP = 0, FREE_OP = 1
  - the header-flag bit position constant
- Sub-module block_ptr: next-fit pointer with wrap-to-1, probe counter and exhaustion flag. All other logic stays in a single FSM file.

## Test plan
All scenarios use ADDR_W = 4, BLOCK_WORDS = 1, so NUM_BLOCKS = 16 with 15 usable.
1. Release reset → 16 INIT writes of 0 to addresses 0–15, then busy = 0 and used_count = 0.
2. Alloc right after init → done in cycle 5, out_address = 1, ok = 1, RAM[1] MSB = 1. A second alloc returns 2.
3. Alloc ×15 → addresses 1..15 and used_count = 15. The 16th alloc → ok = 0, out_address = 0, done in cycle 46.
4. Free 2, then alloc with ptr = 1 after wrap → out_address = 2. Pulse req while busy → ignored.
5. Free 0 and free 5 with BLOCK_WORDS = 2 variant (free 5 is unaligned) → ok = 0, done in cycle 1, no ram_wren. Free 3 twice with ALLOC_FREE_CHECK_EN defined → second free gives ok = 0 and used_count decremented only once.
6. Assert resetn low during a WR cycle → ram_wren = 0 asynchronously, INIT reruns, and the next alloc returns 1.
